// File: rtl/clock_div_tracker.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_tracker
// Summary  : Fast-clock receiver for a divided clock. Samples SLOW_IN,
//            measures its period and high time in CLK cycles, declares lock
//            after LOCK_COUNT identical periods, regenerates the pre-edge
//            strobe and pulses ERR on a ratio change or a missed edge.
// Options  : CLKDIV_TRACK_SYNC_EN - two-flop synchronizer on SLOW_IN
//            (SLOW_IN may then be asynchronous; detection latency +2 cycles)
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_tracker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SLOW_IN,
  output logic             LOCKED,
  output logic             PREEDGE,
  output logic             ERR,
  output logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] HIGH_CNT
);

  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_MATCH = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             s;
  logic             s_q;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_n;
  logic [WIDTH-1:0] period_m1;
  logic [3:0]       match;
  logic [3:0]       match_n;
  logic             err_n;

`ifdef CLKDIV_TRACK_SYNC_EN
  logic [1:0] sync;

  // Two-flop synchronizer; resets high so a high SLOW_IN is not seen as a rise
  always_ff @(posedge CLK) begin
    if (!RST) sync <= 2'b11;
    else      sync <= {sync[0], SLOW_IN};
  end

  assign s = sync[1];
`else
  assign s = SLOW_IN;
`endif

  // Sample history; reset high so a level already high at release is no rise
  always_ff @(posedge CLK) begin
    if (!RST) s_q <= 1'b1;
    else      s_q <= s;
  end

  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

  // Phase counter: restarts at 1 on each rise, so at a rise it holds the period
  always_ff @(posedge CLK) begin
    if (!RST)                   cnt <= '0;
    else if (rise)              cnt <= CNT_ONE;
    else if (state == ST_IDLE)  cnt <= '0;
    else if (cnt != CNT_MAX)    cnt <= cnt + CNT_ONE;
  end

  // High time is captured on each fall once tracking has started
  always_ff @(posedge CLK) begin
    if (!RST)                          HIGH_CNT <= '0;
    else if (fall && state != ST_IDLE) HIGH_CNT <= cnt;
  end

  // State, match counter, measured period and registered error pulse
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= ST_IDLE;
      match  <= '0;
      PERIOD <= '0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_n;
      match  <= match_n;
      PERIOD <= period_n;
      ERR    <= err_n;
    end
  end

  // Next-state decode; a rise always takes priority over timeout/missed edge
  always_comb begin
    state_n  = state;
    match_n  = match;
    period_n = PERIOD;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_MEASURE;
          match_n = '0;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          if (match == '0 || cnt != PERIOD) begin
            period_n = cnt;
            match_n  = 4'd1;
          end else begin
            match_n  = match + 4'd1;
          end
          if (match_n == LOCK_MATCH) state_n = ST_LOCKED;
        end else if (cnt == CNT_MAX) begin
          state_n = ST_IDLE;
          match_n = '0;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          if (cnt != PERIOD) begin
            err_n    = 1'b1;
            period_n = cnt;
            match_n  = 4'd1;
            state_n  = ST_MEASURE;
          end
        end else if (cnt == PERIOD) begin
          err_n   = 1'b1;
          match_n = '0;
          state_n = ST_MEASURE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        match_n = '0;
      end
    endcase
  end

  assign period_m1 = PERIOD - CNT_ONE;
  assign LOCKED    = (state == ST_LOCKED);
  assign PREEDGE   = (state == ST_LOCKED) && (cnt == period_m1);

endmodule
`default_nettype wire
